// File: rtl/noc_beat_assembler_pkg.sv
// Shared types and constants for the NOC beat assembler.
// Header layout, message struct and FSM encoding live here.
package noc_beat_assembler_pkg;

  localparam int BEAT_WIDTH = 32;
  localparam int TAG_WIDTH  = 16;
  localparam int MAX_BEATS  = 4;
  localparam int CNT_WIDTH  = 16;
  localparam int DATA_WIDTH = MAX_BEATS * BEAT_WIDTH;
  localparam int MSG_WIDTH  = TAG_WIDTH + DATA_WIDTH;

  localparam int TAG_LSB = 16;
  localparam int LEN_LSB = 0;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  length;
    logic [DATA_WIDTH-1:0] data;
  } NOCDataH;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    PAY  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Beat k lands in the k-th 32-bit lane counted from the MSB end.
  function automatic logic [DATA_WIDTH-1:0] place_beat(
    input logic [DATA_WIDTH-1:0] data,
    input logic [TAG_WIDTH-1:0]  idx,
    input logic [BEAT_WIDTH-1:0] beat
  );
    logic [DATA_WIDTH-1:0] r;
    r = data;
    for (int k = 0; k < MAX_BEATS; k++) begin
      if (idx == TAG_WIDTH'(k))
        r[DATA_WIDTH-1-BEAT_WIDTH*k -: BEAT_WIDTH] = beat;
    end
    return r;
  endfunction

endpackage

// File: rtl/noc_msg_slot.sv
// Single-entry message holding register.
// A same-cycle enq wins over deq, so the slot can be refilled while draining.
module noc_msg_slot
  import noc_beat_assembler_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enq,
  input  logic [MSG_WIDTH-1:0] i_data,
  input  logic                 i_deq,
  output logic                 o_full,
  output logic [MSG_WIDTH-1:0] o_data
);

  logic                 r_full;
  logic [MSG_WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
    end else if (i_enq) begin
      r_full <= 1'b1;
    end else if (i_deq) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_enq) begin
      r_data <= i_data;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/noc_beat_assembler.sv
// Packs a header beat plus payload beats into one 144-bit NOC message.
// Assembly of the next message overlaps a stalled out slot.
module noc_beat_assembler
  import noc_beat_assembler_pkg::*;
(
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  in_enq__ENA,
  input  logic [BEAT_WIDTH-1:0] in_enq_v,
  output logic                  in_enq__RDY,
  output logic                  out_enq__ENA,
  output logic [MSG_WIDTH-1:0]  out_enq_v,
  input  logic                  out_enq__RDY,
  output logic                  err_len,
  output logic [CNT_WIDTH-1:0]  msg_count
);

  state_t r_state;
  state_t w_next;

  logic [TAG_WIDTH-1:0]  r_tag;
  logic [TAG_WIDTH-1:0]  r_len;
  logic [TAG_WIDTH-1:0]  r_idx;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic                  w_fire;
  logic                  w_drain;
  logic                  w_space;
  logic                  w_last;
  logic                  w_len0;
  logic [TAG_WIDTH-1:0]  w_hdr_tag;
  logic [TAG_WIDTH-1:0]  w_hdr_len;
  logic [DATA_WIDTH-1:0] w_asm;
  logic                  w_enq;
  NOCDataH               w_msg;
  logic                  w_full;

  assign in_enq__RDY = (r_state != HOLD);

  assign w_fire    = in_enq__ENA & in_enq__RDY;
  assign w_drain   = w_full & out_enq__RDY;
  assign w_space   = ~w_full | w_drain;
  assign w_hdr_tag = in_enq_v[TAG_LSB +: TAG_WIDTH];
  assign w_hdr_len = in_enq_v[LEN_LSB +: TAG_WIDTH];
  assign w_len0    = (w_hdr_len == '0);
  assign w_last    = ((r_idx + 16'd1) == r_len);
  assign w_asm     = place_beat(r_data, r_idx, in_enq_v);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= HDR;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      HDR: begin
        if (w_fire) begin
          if (w_len0) w_next = w_space ? HDR : HOLD;
          else        w_next = PAY;
        end
      end
      PAY: begin
        if (w_fire && w_last) w_next = w_space ? HDR : HOLD;
      end
      HOLD: begin
        if (w_drain) w_next = HDR;
      end
      default: w_next = HDR;
    endcase
  end

  // Completing beats bypass the assembly register into the slot.
  always_comb begin
    w_enq = 1'b0;
    w_msg = '0;
    unique case (r_state)
      HDR: begin
        w_enq        = w_fire & w_len0 & w_space;
        w_msg.length = w_hdr_tag;
      end
      PAY: begin
        w_enq        = w_fire & w_last & w_space;
        w_msg.length = r_tag;
        w_msg.data   = w_asm;
      end
      HOLD: begin
        w_enq        = w_drain;
        w_msg.length = r_tag;
        w_msg.data   = r_data;
      end
      default: begin
        w_enq = 1'b0;
        w_msg = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_tag  <= '0;
      r_len  <= '0;
      r_idx  <= '0;
      r_data <= '0;
    end else if (w_fire && r_state == HDR) begin
      r_tag  <= w_hdr_tag;
      r_len  <= w_hdr_len;
      r_idx  <= '0;
      r_data <= '0;
    end else if (w_fire && r_state == PAY) begin
      r_idx  <= r_idx + 16'd1;
      r_data <= w_asm;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_err <= 1'b0;
    end else if (w_fire && r_state == HDR
                 && w_hdr_len > TAG_WIDTH'(MAX_BEATS)) begin
      r_err <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (w_drain) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign err_len   = r_err;
  assign msg_count = r_cnt;

  noc_msg_slot u_slot (
    .clk    (CLK),
    .rst_n  (nRST),
    .i_enq  (w_enq),
    .i_data (w_msg),
    .i_deq  (w_drain),
    .o_full (w_full),
    .o_data (out_enq_v)
  );

  assign out_enq__ENA = w_full;

endmodule

// File: tb/tb_noc_beat_assembler.sv
// Directed and random checks of noc_beat_assembler against a
// queue-based message model built from the header/payload rules.
module tb_noc_beat_assembler;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         in_enq__ENA = 1'b0;
  logic [31:0]  in_enq_v = '0;
  logic         in_enq__RDY;
  logic         out_enq__ENA;
  logic [143:0] out_enq_v;
  logic         out_enq__RDY = 1'b0;
  logic         err_len;
  logic [15:0]  msg_count;

  noc_beat_assembler dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_enq__ENA  (in_enq__ENA),
    .in_enq_v     (in_enq_v),
    .in_enq__RDY  (in_enq__RDY),
    .out_enq__ENA (out_enq__ENA),
    .out_enq_v    (out_enq_v),
    .out_enq__RDY (out_enq__RDY),
    .err_len      (err_len),
    .msg_count    (msg_count)
  );

  always #5 CLK = ~CLK;

  int           compared = 0;
  int           mismatched = 0;
  logic [143:0] exp_q[$];
  logic [31:0]  pay[$];
  int unsigned  mdl_cnt = 0;
  logic         exp_err = 1'b0;
  bit           rand_rdy = 1'b0;
  logic         fix_rdy = 1'b0;

  task automatic chk(input string tag, input logic [143:0] obs,
                     input logic [143:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] build(input logic [15:0] tag,
                                         input int len);
    logic [127:0] d;
    d = '0;
    for (int k = 0; k < len && k < 4; k++)
      d[127-32*k -: 32] = pay[k];
    return {tag, d};
  endfunction

  task automatic tick();
    logic         xfer;
    logic [143:0] v;
    out_enq__RDY = rand_rdy ? ($urandom_range(0, 3) != 0) : fix_rdy;
    #1;
    xfer = out_enq__ENA & out_enq__RDY;
    v = out_enq_v;
    @(posedge CLK);
    #1;
    if (xfer) begin
      compared++;
      assert (exp_q.size() != 0) else begin
        mismatched++;
        $error("FAIL unexpected_msg: observed %0h expected none", v);
      end
      if (exp_q.size() != 0) chk("msg_order", v, exp_q.pop_front());
      mdl_cnt++;
    end
  endtask

  task automatic send_beat(input logic [31:0] b);
    int w;
    w = 0;
    in_enq__ENA = 1'b0;
    while (!in_enq__RDY && w < 200) begin
      tick();
      w++;
    end
    compared++;
    assert (in_enq__RDY === 1'b1) else begin
      mismatched++;
      $error("FAIL rdy_timeout: observed %b expected 1", in_enq__RDY);
    end
    if (in_enq__RDY === 1'b1) begin
      in_enq_v = b;
      in_enq__ENA = 1'b1;
      tick();
      in_enq__ENA = 1'b0;
    end
  endtask

  task automatic send_msg(input logic [15:0] tag, input int len);
    exp_q.push_back(build(tag, len));
    if (len > 4) exp_err = 1'b1;
    send_beat({tag, 16'(len)});
    if (len > 4) chk("err_hdr", 144'(err_len), 144'd1);
    for (int k = 0; k < len; k++) send_beat(pay[k]);
  endtask

  initial begin
    int w;
    int len;
    logic [15:0] tag;

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ena", 144'(out_enq__ENA), 144'd0);
    chk("rst_v", out_enq_v, 144'd0);
    chk("rst_rdy", 144'(in_enq__RDY), 144'd1);
    chk("rst_err", 144'(err_len), 144'd0);
    chk("rst_cnt", 144'(msg_count), 144'd0);
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK);
    #1;

    fix_rdy = 1'b1;
    pay = '{32'hDEADBEEF};
    send_msg(16'h0003, 1);
    chk("t1_ena", 144'(out_enq__ENA), 144'd1);
    chk("t1_val", out_enq_v, {16'h0003, 32'hDEADBEEF, 96'h0});
    tick();
    chk("t1_cnt", 144'(msg_count), 144'd1);

    for (int i = 0; i < 3; i++) begin
      send_msg(16'h0000, 0);
      chk("len0_ena", 144'(out_enq__ENA), 144'd1);
      chk("len0_val", out_enq_v, 144'd0);
    end
    tick();
    chk("len0_cnt", 144'(msg_count), 144'd4);

    pay = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    send_msg(16'h0005, 4);
    chk("four_val", out_enq_v,
        {16'h0005, 128'h11111111_22222222_33333333_44444444});
    tick();

    fix_rdy = 1'b0;
    pay = '{32'h000000A1};
    send_msg(16'h0021, 1);
    pay = '{32'h000000B2};
    send_msg(16'h0022, 1);
    chk("hold_rdy", 144'(in_enq__RDY), 144'd0);
    chk("hold_ena", 144'(out_enq__ENA), 144'd1);
    chk("hold_v1", out_enq_v, {16'h0021, 32'h000000A1, 96'h0});
    fix_rdy = 1'b1;
    tick();
    chk("hold_rdy_back", 144'(in_enq__RDY), 144'd1);
    chk("hold_v2", out_enq_v, {16'h0022, 32'h000000B2, 96'h0});
    tick();
    chk("hold_empty", 144'(out_enq__ENA), 144'd0);
    chk("hold_cnt", 144'(msg_count), 144'd7);

    chk("err_pre", 144'(err_len), 144'd0);
    pay = '{32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2,
            32'hC3C3C3C3, 32'hC4C4C4C4, 32'hC5C5C5C5};
    send_msg(16'h0003, 6);
    chk("err_val", out_enq_v,
        {16'h0003, 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3});
    pay = '{32'hE5E5E5E5};
    send_msg(16'h0044, 1);
    chk("err_next_val", out_enq_v, {16'h0044, 32'hE5E5E5E5, 96'h0});
    chk("err_sticky", 144'(err_len), 144'd1);
    tick();

    fix_rdy = 1'b0;
    pay = '{32'hF1F1F1F1};
    send_msg(16'h0051, 1);
    send_beat(32'h0052_0002);
    send_beat(32'hF2F2F2F2);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_ena", 144'(out_enq__ENA), 144'd0);
    chk("arst_v", out_enq_v, 144'd0);
    chk("arst_rdy", 144'(in_enq__RDY), 144'd1);
    chk("arst_err", 144'(err_len), 144'd0);
    chk("arst_cnt", 144'(msg_count), 144'd0);
    exp_q.delete();
    mdl_cnt = 0;
    exp_err = 1'b0;
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK);
    #1;
    fix_rdy = 1'b1;
    pay = '{32'hF3F3F3F3};
    send_msg(16'h0053, 1);
    chk("arst_hdr_val", out_enq_v, {16'h0053, 32'hF3F3F3F3, 96'h0});
    tick();
    chk("arst_cnt2", 144'(msg_count), 144'd1);

    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(0, 6);
      tag = 16'($urandom);
      pay.delete();
      for (int k = 0; k < len; k++) pay.push_back($urandom);
      send_msg(tag, len);
    end
    rand_rdy = 1'b0;
    fix_rdy = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      tick();
      w++;
    end
    tick();
    chk("rand_drained", 144'(exp_q.size()), 144'd0);
    chk("rand_cnt", 144'(msg_count), 144'(16'(mdl_cnt)));
    chk("rand_err", 144'(err_len), 144'(exp_err));
    chk("rand_idle", 144'(out_enq__ENA), 144'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
